// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// Purpose:
//   Consumer side of the branch comparator in the single-cycle core. It:
//   - tells the comparator whether to do an unsigned compare;
//   - turns br_less/br_equal plus funct3 into a taken decision;
//   - computes branch and jump targets;
//   - owns the PC register.
//   A taken control transfer whose target has bit 1 set is misaligned. It
//   traps, and the block holds in TRAP until trap_ack_i arrives. The PC then
//   resumes at TRAP_VEC.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   TRAP_VEC  PC loaded when leaving TRAP
//   CNT_W     perf counter width (present only with BRU_PERF_CNT_EN)
//
// Optional feature macro:
//   BRU_PERF_CNT_EN  adds br_cnt_o / taken_cnt_o retirement counters
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   instr_valid_i     current instruction valid
//   stall_i           hold PC this cycle
//   is_branch_i       conditional branch
//   is_jal_i          JAL
//   is_jalr_i         JALR (priority jalr > jal > branch)
//   funct3_i          branch condition select
//   br_less_i         comparator: rs1 < rs2
//   br_equal_i        comparator: rs1 == rs2
//   imm_i             sign-extended immediate
//   rs1_data_i        JALR base register
//   trap_ack_i        trap handler acknowledge (only honoured in TRAP)
//   br_unsigned_o     to comparator: funct3[1]
//   pc_o              registered PC
//   pc_plus4_o        pc_o + 4, the link value
//   br_taken_o        control transfer taken this cycle (combinational)
//   illegal_o         branch with reserved funct3 010/011 (combinational)
//   trap_o            block is in TRAP
//   trap_pc_o         PC of the faulting instruction
//   br_cnt_o          retired conditional branches (BRU_PERF_CNT_EN)
//   taken_cnt_o       retired taken branches/jumps (BRU_PERF_CNT_EN)
//   state_o           debug view of the FSM state (0 = RUN, 1 = TRAP)
//
// Handshake: an instruction is consumed (retires) on a rising edge where the
// FSM is in RUN with instr_valid_i=1 and stall_i=0, and the edge does not
// trap. stall_i acts as an inverted ready, so valid must hold its
// instruction until that edge.
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`ifdef BRU_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  input  logic             stall_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      rs1_data_i,
  input  logic             trap_ack_i,
  output logic             br_unsigned_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             br_taken_o,
  output logic             illegal_o,
  output logic             trap_o,
  output logic [31:0]      trap_pc_o,
`ifdef BRU_PERF_CNT_EN
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
`endif
  output logic             state_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        cond_taken;
  logic        xfer;        // any control transfer, before gating
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        misalign;    // taken transfer to a non-word-aligned target
  logic        advance;     // RUN-state edge with a consumable instruction
  logic        retire;

  // Condition decode. The reserved encodings 010/011 never take.
  always_comb begin
    cond_taken = 1'b0;
    case (funct3_i)
      3'b000:  cond_taken =  br_equal_i;
      3'b001:  cond_taken = !br_equal_i;
      3'b100:  cond_taken =  br_less_i;
      3'b101:  cond_taken = !br_less_i;
      3'b110:  cond_taken =  br_less_i;
      3'b111:  cond_taken = !br_less_i;
      default: cond_taken = 1'b0;
    endcase
  end

  assign br_unsigned_o = funct3_i[1];
  assign illegal_o     = is_branch_i && (funct3_i[2:1] == 2'b01);
  assign xfer          = is_jalr_i || is_jal_i || (is_branch_i && cond_taken);
  assign br_taken_o    = xfer && instr_valid_i && (state_q == ST_RUN);

  // JALR wins over JAL and branch. Only JALR clears bit 0 of its target.
  assign target     = is_jalr_i ? ((rs1_data_i + imm_i) & ~32'h1) : (pc_o + imm_i);
  assign pc_plus4_o = pc_o + 32'd4;
  assign next_pc    = br_taken_o ? target : pc_plus4_o;
  // br_taken_o is already 0 outside RUN, so a not-taken branch never traps.
  assign misalign   = br_taken_o && target[1];
  assign advance    = (state_q == ST_RUN) && instr_valid_i && !stall_i;
  assign retire     = advance && !misalign;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (advance && misalign) state_d = ST_TRAP;
      ST_TRAP: if (trap_ack_i)          state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    trap_o  = (state_q == ST_TRAP);
    state_o = state_q;
  end

  // PC and faulting-PC registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o      <= RESET_PC;
      trap_pc_o <= 32'h0;
    end else if (state_q == ST_TRAP) begin
      if (trap_ack_i) pc_o <= TRAP_VEC;
    end else if (advance) begin
      if (misalign) trap_pc_o <= pc_o;
      else          pc_o      <= next_pc;
    end
  end

`ifdef BRU_PERF_CNT_EN
  // A branch flag overridden by a set jal/jalr flag retires as a jump,
  // not as a conditional branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_o    <= '0;
      taken_cnt_o <= '0;
    end else if (retire) begin
      if (is_branch_i && !is_jal_i && !is_jalr_i) br_cnt_o <= br_cnt_o + CNT_W'(1);
      if (br_taken_o) taken_cnt_o <= taken_cnt_o + CNT_W'(1);
    end
  end
`else
  // Without the perf counters, retirement has no consumer beyond the PC.
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
